// File: rtl/parking_gate_if.sv
// Lane request/sensor inputs and gate/occupancy outputs of the shared barrier gate.
interface parking_gate_if #(
   parameter int CNT_W = 5
);
   logic             entry_req;
   logic             exit_req;
   logic             entry_passed;
   logic             exit_passed;
   logic             entry_grant;
   logic             exit_grant;
   logic             gate_open_cmd;
   logic             gate_close_cmd;
   logic             lot_full;
   logic [CNT_W-1:0] occupancy;
   logic             timeout_alarm;

   modport master (
      output entry_req, exit_req, entry_passed, exit_passed,
      input  entry_grant, exit_grant, gate_open_cmd, gate_close_cmd,
             lot_full, occupancy, timeout_alarm
   );

   modport slave (
      input  entry_req, exit_req, entry_passed, exit_passed,
      output entry_grant, exit_grant, gate_open_cmd, gate_close_cmd,
             lot_full, occupancy, timeout_alarm
   );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Single barrier gate shared by entry and exit lanes: round-robin arbitration, timed travel,
// occupancy tracking. Define EXIT_PRIORITY_EN to always favour the exit lane on a tie.
module parking_gate_arbiter #(
   parameter int CAPACITY      = 16,
   parameter int CNT_W         = 5,
   parameter int TRAVEL_CYCLES = 8,
   parameter int PASS_TIMEOUT  = 64
) (
   input  logic          clk,
   input  logic          rst,
   parking_gate_if.slave bus
);
   typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;

   localparam int TMR_MAX = (TRAVEL_CYCLES > PASS_TIMEOUT) ? TRAVEL_CYCLES : PASS_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
   localparam logic [TMR_W-1:0] PASS_LAST   = TMR_W'(PASS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAP         = CNT_W'(CAPACITY);

   // Owner and last_served encode 1 = entry lane, 0 = exit lane.
   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_served_q, last_served_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             entry_grant_q, entry_grant_d;
   logic             exit_grant_q, exit_grant_d;
   logic             open_cmd_q, open_cmd_d;
   logic             close_cmd_q, close_cmd_d;
   logic             alarm_q, alarm_d;
   logic             timeout_hit;
   logic             full;
   logic             entry_eligible;
   logic             owner_passed;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CAP) ? v : v + 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   assign full           = (occ_q == CAP);
   assign entry_eligible = bus.entry_req && !full;
   assign owner_passed   = owner_q ? bus.entry_passed : bus.exit_passed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_served_q <= 1'b1;
         timer_q       <= '0;
         occ_q         <= '0;
         entry_grant_q <= 1'b0;
         exit_grant_q  <= 1'b0;
         open_cmd_q    <= 1'b0;
         close_cmd_q   <= 1'b0;
         alarm_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_served_q <= last_served_d;
         timer_q       <= timer_d;
         occ_q         <= occ_d;
         entry_grant_q <= entry_grant_d;
         exit_grant_q  <= exit_grant_d;
         open_cmd_q    <= open_cmd_d;
         close_cmd_q   <= close_cmd_d;
         alarm_q       <= alarm_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_served_d = last_served_q;
      timer_d       = timer_q;
      occ_d         = occ_q;
      timeout_hit   = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (entry_eligible || bus.exit_req) begin
               state_d = OPENING;
`ifdef EXIT_PRIORITY_EN
               owner_d = !bus.exit_req;
`else
               if (entry_eligible && bus.exit_req) owner_d = !last_served_q;
               else                                owner_d = entry_eligible;
`endif
               last_served_d = owner_d;
            end
         end
         OPENING: begin
            if (timer_q == TRAVEL_LAST) begin
               state_d = WAIT_PASS;
               timer_d = '0;
            end else timer_d = timer_q + 1'b1;
         end
         WAIT_PASS: begin
            // A pass in the final timeout cycle still counts, so it is tested first.
            if (owner_passed) begin
               state_d = CLOSING;
               timer_d = '0;
               occ_d   = owner_q ? sat_inc(occ_q) : sat_dec(occ_q);
            end else if (timer_q == PASS_LAST) begin
               state_d     = CLOSING;
               timer_d     = '0;
               timeout_hit = 1'b1;
            end else timer_d = timer_q + 1'b1;
         end
         CLOSING: begin
            if (timer_q == TRAVEL_LAST) begin
               state_d = IDLE;
               timer_d = '0;
            end else timer_d = timer_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change together with it.
   always_comb begin
      entry_grant_d = (state_d != IDLE) && owner_d;
      exit_grant_d  = (state_d != IDLE) && !owner_d;
      open_cmd_d    = (state_d == OPENING);
      close_cmd_d   = (state_d == CLOSING);
      alarm_d       = timeout_hit;
   end

   assign bus.entry_grant    = entry_grant_q;
   assign bus.exit_grant     = exit_grant_q;
   assign bus.gate_open_cmd  = open_cmd_q;
   assign bus.gate_close_cmd = close_cmd_q;
   assign bus.lot_full       = full;
   assign bus.occupancy      = occ_q;
   assign bus.timeout_alarm  = alarm_q;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter (CAPACITY=16, TRAVEL_CYCLES=8, PASS_TIMEOUT=64).
module tb_parking_gate_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   parking_gate_if #(.CNT_W(5)) bus();

   parking_gate_arbiter #(
      .CAPACITY(16), .CNT_W(5), .TRAVEL_CYCLES(8), .PASS_TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.entry_req = 1'b0; bus.exit_req = 1'b0;
      bus.entry_passed = 1'b0; bus.exit_passed = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // who: 1 = entry granted, 2 = exit granted, 0 = nothing within the bound
   task automatic wait_grant(output int who);
      int n;
      n = 0;
      while (!(bus.entry_grant || bus.exit_grant) && n < 60) begin tick(); n++; end
      who = bus.entry_grant ? 1 : (bus.exit_grant ? 2 : 0);
   endtask

   task automatic wait_open_done();
      int n;
      n = 0;
      while (bus.gate_open_cmd && n < 40) begin tick(); n++; end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((bus.entry_grant || bus.exit_grant) && n < 120) begin tick(); n++; end
      check({tag, "_idle_reached"}, int'(n < 120), 1);
   endtask

   task automatic finish_txn(input string tag);
      logic ent;
      ent = bus.entry_grant;
      wait_open_done();
      if (ent) bus.entry_passed = 1'b1; else bus.exit_passed = 1'b1;
      tick();
      bus.entry_passed = 1'b0; bus.exit_passed = 1'b0;
      wait_idle(tag);
   endtask

   task automatic serve(input bit lane_entry, input string tag);
      int who;
      if (lane_entry) bus.entry_req = 1'b1; else bus.exit_req = 1'b1;
      wait_grant(who);
      check({tag, "_grant"}, who, lane_entry ? 1 : 2);
      bus.entry_req = 1'b0; bus.exit_req = 1'b0;
      finish_txn(tag);
   endtask

   initial begin
      int who, cnt, n, early, exp_second;

      // Single entry transaction with exact timing
      do_reset();
      check("rst_entry_grant", bus.entry_grant, 0);
      check("rst_exit_grant", bus.exit_grant, 0);
      check("rst_open", bus.gate_open_cmd, 0);
      check("rst_close", bus.gate_close_cmd, 0);
      check("rst_occ", bus.occupancy, 0);
      check("rst_alarm", bus.timeout_alarm, 0);
      check("rst_full", bus.lot_full, 0);
      bus.entry_req = 1'b1;
      tick();
      bus.entry_req = 1'b0;
      check("t1_entry_grant_c1", bus.entry_grant, 1);
      check("t1_exit_grant_c1", bus.exit_grant, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.gate_open_cmd && !bus.gate_close_cmd) cnt++;
         tick();
      end
      check("t1_open_cycles", cnt, 8);
      check("t1_waitpass_open", bus.gate_open_cmd, 0);
      check("t1_waitpass_close", bus.gate_close_cmd, 0);
      check("t1_waitpass_grant", bus.entry_grant, 1);
      bus.entry_passed = 1'b1;
      tick();
      bus.entry_passed = 1'b0;
      check("t1_occ_after_pass", bus.occupancy, 1);
      check("t1_alarm", bus.timeout_alarm, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.gate_close_cmd && !bus.gate_open_cmd) cnt++;
         tick();
      end
      check("t1_close_cycles", cnt, 8);
      check("t1_idle_grants", int'(bus.entry_grant | bus.exit_grant), 0);
      check("t1_idle_close", bus.gate_close_cmd, 0);

      // Both lanes held: tie-break sequence
`ifdef EXIT_PRIORITY_EN
      exp_second = 2;
`else
      exp_second = 1;
`endif
      do_reset();
      bus.entry_req = 1'b1; bus.exit_req = 1'b1;
      wait_grant(who); check("t2_first", who, 2); finish_txn("t2_a");
      wait_grant(who); check("t2_second", who, exp_second); finish_txn("t2_b");
      wait_grant(who); check("t2_third", who, 2); finish_txn("t2_c");
      bus.entry_req = 1'b0; bus.exit_req = 1'b0;
      check("t2_occ", bus.occupancy, 0);

      // Fill the lot, entry blocked, one exit reopens entry
      do_reset();
      for (int i = 0; i < 16; i++) serve(1'b1, "t3_fill");
      check("t3_occ_full", bus.occupancy, 16);
      check("t3_lot_full", bus.lot_full, 1);
      bus.entry_req = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.entry_grant || bus.exit_grant) cnt++;
         tick();
      end
      check("t3_full_no_grant", cnt, 0);
      bus.exit_req = 1'b1;
      wait_grant(who);
      check("t3_exit_grant", who, 2);
      bus.exit_req = 1'b0;
      finish_txn("t3_exit");
      check("t3_occ_after_exit", bus.occupancy, 15);
      check("t3_not_full", bus.lot_full, 0);
      wait_grant(who);
      check("t3_entry_after_exit", who, 1);
      bus.entry_req = 1'b0;
      finish_txn("t3_entry");
      check("t3_occ_refull", bus.occupancy, 16);

      // Pass timeout, foreign sensor ignored
      do_reset();
      serve(1'b1, "t4_pre");
      bus.entry_req = 1'b1;
      wait_grant(who);
      check("t4_grant", who, 1);
      bus.entry_req = 1'b0;
      wait_open_done();
      check("t4_in_waitpass", int'(bus.gate_open_cmd | bus.gate_close_cmd), 0);
      n = 0; early = 0;
      bus.exit_passed = 1'b1;
      while (!bus.gate_close_cmd && n < 100) begin
         tick(); n++;
         bus.exit_passed = 1'b0;
         if (bus.timeout_alarm && !bus.gate_close_cmd) early++;
      end
      check("t4_wait_cycles", n, 64);
      check("t4_early_alarm", early, 0);
      check("t4_alarm_pulse", bus.timeout_alarm, 1);
      check("t4_occ_unchanged", bus.occupancy, 1);
      tick();
      check("t4_alarm_single", bus.timeout_alarm, 0);
      check("t4_closing", bus.gate_close_cmd, 1);
      wait_idle("t4");

      // Pass in the last timeout cycle wins over the alarm
      bus.entry_req = 1'b1;
      wait_grant(who);
      check("t4b_grant", who, 1);
      bus.entry_req = 1'b0;
      wait_open_done();
      n = 0;
      while (!bus.gate_close_cmd && n < 100) begin
         bus.entry_passed = (n == 63);
         tick(); n++;
      end
      bus.entry_passed = 1'b0;
      check("t4b_wait_cycles", n, 64);
      check("t4b_no_alarm", bus.timeout_alarm, 0);
      check("t4b_occ", bus.occupancy, 2);
      wait_idle("t4b");

      // Reset mid-OPENING
      do_reset();
      for (int i = 0; i < 3; i++) serve(1'b1, "t5_pre");
      check("t5_occ3", bus.occupancy, 3);
      bus.entry_req = 1'b1;
      wait_grant(who);
      tick(); tick();
      check("t5_opening", bus.gate_open_cmd, 1);
      rst = 1'b1;
      bus.entry_req = 1'b0;
      tick();
      check("t5_rst_open", bus.gate_open_cmd, 0);
      check("t5_rst_grants", int'(bus.entry_grant | bus.exit_grant), 0);
      check("t5_rst_occ", bus.occupancy, 0);
      rst = 1'b0;
      serve(1'b0, "t5_exit");
      check("t5_occ_sat0", bus.occupancy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
